// File: rtl/cpu_pkg.sv
// Shared CPU definitions: phase encodings, sequencer states, opcodes and
// instruction field positions used by the front end and the execute stage.
package cpu_pkg;

   localparam int PC_W_DEF = 8;
   localparam int IW_DEF   = 15;

   // Externally visible phase encoding (IDLE reports as FETCH)
   typedef enum logic [1:0] {
      PH_FETCH  = 2'd0,
      PH_DECODE = 2'd1,
      PH_EXEC   = 2'd2,
      PH_WB     = 2'd3
   } phase_t;

   // Internal sequencer states; IDLE is kept distinct from FETCH
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB
   } seq_state_t;

   localparam logic [3:0] OP_MOV = 4'h0;
   localparam logic [3:0] OP_JMP = 4'hC;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Instruction field bit positions
   localparam int OPC_MSB  = 14;
   localparam int OPC_LSB  = 11;
   localparam int RA_MSB   = 10;
   localparam int RA_LSB   = 8;
   localparam int RB_MSB   = 7;
   localparam int RB_LSB   = 5;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   function automatic logic is_halt(input logic [3:0] op);
      return (op == OP_HLT);
   endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Bus between the fetch/decode front end, the instruction ROM and execute.
interface fetch_decode_if #(
   parameter int PC_W = 8,
   parameter int IW   = 15
);
   logic            RUN;
   logic [PC_W-1:0] P_COUNT;
   logic [PC_W-1:0] ROM_ADDR;
   logic [IW-1:0]   ROM_DATA;
   logic [3:0]      OP_CODE;
   logic [2:0]      REG_A_SEL;
   logic [2:0]      REG_B_SEL;
   logic [7:0]      OP_DATA;
   logic            EX_EN;
   logic            WB_EN;
   logic            HALTED;
   logic [1:0]      PHASE;

   // Front end side
   modport master (
      input  RUN, P_COUNT, ROM_DATA,
      output ROM_ADDR, OP_CODE, REG_A_SEL, REG_B_SEL, OP_DATA,
             EX_EN, WB_EN, HALTED, PHASE
   );

   // ROM / execute / control side
   modport slave (
      output RUN, P_COUNT, ROM_DATA,
      input  ROM_ADDR, OP_CODE, REG_A_SEL, REG_B_SEL, OP_DATA,
             EX_EN, WB_EN, HALTED, PHASE
   );
endinterface

// File: rtl/phase_seq.sv
// Four-phase instruction sequencer with RUN pause, sticky halt and
// one-cycle execute / write-back strobes.
module phase_seq
   import cpu_pkg::*;
#(
   parameter bit RUN_ON_RESET = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       is_hlt,
   output logic       ld_addr,
   output logic       ld_ir,
   output logic       ex_en,
   output logic       wb_en,
   output logic       halted,
   output logic [1:0] phase
);

   seq_state_t state_reg;
   phase_t     phase_reg;

   // Load strobes are decoded from the state so the fetch address and IR
   // capture line up with the state register edge.
   assign ld_addr = (state_reg == ST_FETCH) && run;
   assign ld_ir   = (state_reg == ST_DECODE);
   assign phase   = phase_reg;

   // State register with registered strobes, halt flag and phase
   always_ff @(posedge clk) begin
      if (rst) begin
         if (RUN_ON_RESET) state_reg <= ST_FETCH;
         else              state_reg <= ST_IDLE;
         phase_reg <= PH_FETCH;
         ex_en     <= 1'b0;
         wb_en     <= 1'b0;
         halted    <= 1'b0;
      end else begin
         ex_en <= 1'b0;
         wb_en <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (run && !halted) state_reg <= ST_FETCH;
               phase_reg <= PH_FETCH;
            end
            ST_FETCH: begin
               if (run) begin
                  state_reg <= ST_DECODE;
                  phase_reg <= PH_DECODE;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            ST_DECODE: begin
               state_reg <= ST_EXEC;
               phase_reg <= PH_EXEC;
               ex_en     <= 1'b1;
            end
            ST_EXEC: begin
               state_reg <= ST_WB;
               phase_reg <= PH_WB;
               wb_en     <= 1'b1;
            end
            ST_WB: begin
               phase_reg <= PH_FETCH;
               if (is_hlt) begin
                  halted    <= 1'b1;
                  state_reg <= ST_IDLE;
               end else if (!run) begin
                  state_reg <= ST_IDLE;
               end else begin
                  state_reg <= ST_FETCH;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               phase_reg <= PH_FETCH;
            end
         endcase
      end
   end

endmodule

// File: rtl/fetch_decode.sv
// CPU front end: fetch address register, instruction register and field
// split, driven by the phase sequencer.
module fetch_decode
   import cpu_pkg::*;
#(
   parameter int PC_W         = PC_W_DEF,
   parameter int IW           = IW_DEF,
   parameter bit RUN_ON_RESET = 1'b1
) (
   input  logic             CLK,
   input  logic             RESET,
   fetch_decode_if.master   bus
);

   logic [PC_W-1:0] rom_addr_reg;
   logic [IW-1:0]   ir_reg;
   logic            ld_addr;
   logic            ld_ir;
   logic            is_hlt;

   assign is_hlt = is_halt(ir_reg[OPC_MSB:OPC_LSB]);

   phase_seq #(
      .RUN_ON_RESET (RUN_ON_RESET)
   ) u_seq (
      .clk     (CLK),
      .rst     (RESET),
      .run     (bus.RUN),
      .is_hlt  (is_hlt),
      .ld_addr (ld_addr),
      .ld_ir   (ld_ir),
      .ex_en   (bus.EX_EN),
      .wb_en   (bus.WB_EN),
      .halted  (bus.HALTED),
      .phase   (bus.PHASE)
   );

   // Fetch address captured in FETCH, instruction word captured in DECODE
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rom_addr_reg <= '0;
         ir_reg       <= '0;
      end else begin
         if (ld_addr) rom_addr_reg <= bus.P_COUNT;
         if (ld_ir)   ir_reg       <= bus.ROM_DATA;
      end
   end

   assign bus.ROM_ADDR  = rom_addr_reg;
   assign bus.OP_CODE   = ir_reg[OPC_MSB:OPC_LSB];
   assign bus.REG_A_SEL = ir_reg[RA_MSB:RA_LSB];
   assign bus.REG_B_SEL = ir_reg[RB_MSB:RB_LSB];
   assign bus.OP_DATA   = ir_reg[DATA_MSB:DATA_LSB];

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: table of instructions with hand-decoded
// fields, plus hand sequences for halt, RUN pause, reset abort and PC wrap.
module tb_fetch_decode;

   typedef struct {
      logic [7:0]  pc;
      logic [14:0] word;
      logic [3:0]  op;
      logic [2:0]  a;
      logic [2:0]  b;
      logic [7:0]  data;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] rom [256];
   vec_t        tab [6];
   vec_t        v_hlt;
   vec_t        v_jmp;

   int checks = 0;
   int errors = 0;
   int ex_cnt = 0;
   int wb_cnt = 0;
   int overlap_cnt = 0;

   fetch_decode_if #(.PC_W(8), .IW(15)) bus ();

   fetch_decode #(.PC_W(8), .IW(15), .RUN_ON_RESET(1'b1)) dut (
      .CLK   (clk),
      .RESET (reset),
      .bus   (bus)
   );

   // Instruction ROM: the address register loads at the end of FETCH and
   // the word is presented during DECODE.
   assign bus.ROM_DATA = rom[bus.ROM_ADDR];

   always #5 clk = ~clk;

   // Strobe pulse counting and overlap detection
   always @(negedge clk) begin
      if (bus.EX_EN) ex_cnt++;
      if (bus.WB_EN) wb_cnt++;
      if (bus.EX_EN && bus.WB_EN) overlap_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required $finish before it");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"}, bus.ROM_ADDR, 0);
      chk({tag, "_op"}, bus.OP_CODE, 0);
      chk({tag, "_ra"}, bus.REG_A_SEL, 0);
      chk({tag, "_rb"}, bus.REG_B_SEL, 0);
      chk({tag, "_data"}, bus.OP_DATA, 0);
      chk({tag, "_ex"}, bus.EX_EN, 0);
      chk({tag, "_wb"}, bus.WB_EN, 0);
      chk({tag, "_halt"}, bus.HALTED, 0);
      chk({tag, "_phase"}, bus.PHASE, 0);
   endtask

   // Reset for two edges with RUN high, check outputs, release at a negedge
   // so that the following cycle is FETCH.
   task automatic do_reset();
      reset   = 1'b1;
      bus.RUN = 1'b1;
      step();
      step();
      chk_reset_vals("rst");
      reset = 1'b0;
   endtask

   // Called at the negedge of a FETCH cycle; returns at the negedge after WB.
   task automatic run_instr(input vec_t v);
      string t;
      t = $sformatf("pc%02h", v.pc);
      bus.P_COUNT = v.pc;
      chk({t, "_fetch_phase"}, bus.PHASE, 0);
      chk({t, "_fetch_ex"}, bus.EX_EN, 0);
      step();
      chk({t, "_dec_phase"}, bus.PHASE, 1);
      chk({t, "_dec_addr"}, bus.ROM_ADDR, v.pc);
      chk({t, "_dec_ex"}, bus.EX_EN, 0);
      step();
      chk({t, "_exec_phase"}, bus.PHASE, 2);
      chk({t, "_exec_ex"}, bus.EX_EN, 1);
      chk({t, "_exec_wb"}, bus.WB_EN, 0);
      chk({t, "_op"}, bus.OP_CODE, v.op);
      chk({t, "_ra"}, bus.REG_A_SEL, v.a);
      chk({t, "_rb"}, bus.REG_B_SEL, v.b);
      chk({t, "_data"}, bus.OP_DATA, v.data);
      step();
      chk({t, "_wb_phase"}, bus.PHASE, 3);
      chk({t, "_wb_ex"}, bus.EX_EN, 0);
      chk({t, "_wb_wb"}, bus.WB_EN, 1);
      chk({t, "_wb_op"}, bus.OP_CODE, v.op);
      step();
   endtask

   initial begin
      int ex_base;
      int wb_base;

      tab[0] = '{8'h00, 15'h4123, 4'h8, 3'd1, 3'd1, 8'h23};
      tab[1] = '{8'h01, 15'h0A5C, 4'h1, 3'd2, 3'd2, 8'h5C};
      tab[2] = '{8'h02, 15'h3FFF, 4'h7, 3'd7, 3'd7, 8'hFF};
      tab[3] = '{8'h03, 15'h5281, 4'hA, 3'd2, 3'd4, 8'h81};
      tab[4] = '{8'h04, 15'h2100, 4'h4, 3'd1, 3'd0, 8'h00};
      tab[5] = '{8'h05, 15'h1EE0, 4'h3, 3'd6, 3'd7, 8'hE0};
      v_hlt  = '{8'h02, 15'h7800, 4'hF, 3'd0, 3'd0, 8'h00};
      v_jmp  = '{8'hFF, 15'h6000, 4'hC, 3'd0, 3'd0, 8'h00};

      for (int i = 0; i < 256; i++) rom[i] = 15'h0000;
      for (int i = 0; i < 6; i++) rom[tab[i].pc] = tab[i].word;
      rom[255] = v_jmp.word;

      reset       = 1'b1;
      bus.RUN     = 1'b1;
      bus.P_COUNT = 8'h00;

      // Straight-line program 0..5
      do_reset();
      chk("c1_addr", bus.ROM_ADDR, 0);
      ex_base = ex_cnt;
      wb_base = wb_cnt;
      for (int i = 0; i < 6; i++) run_instr(tab[i]);
      chk("line_ex_pulses", ex_cnt - ex_base, 6);
      chk("line_wb_pulses", wb_cnt - wb_base, 6);

      // HLT at address 2: sticky, RUN ignored, cleared only by reset
      rom[2] = v_hlt.word;
      do_reset();
      run_instr(tab[0]);
      run_instr(tab[1]);
      run_instr(v_hlt);
      bus.P_COUNT = 8'h03;
      chk("hlt_halted", bus.HALTED, 1);
      ex_base = ex_cnt;
      for (int i = 0; i < 8; i++) begin
         bus.RUN = i[0];
         step();
         chk("hlt_hold_halted", bus.HALTED, 1);
         chk("hlt_hold_addr", bus.ROM_ADDR, 2);
         chk("hlt_hold_phase", bus.PHASE, 0);
      end
      chk("hlt_no_ex", ex_cnt - ex_base, 0);
      do_reset();
      rom[2] = tab[2].word;

      // RUN dropped during EXEC of the instruction at 3
      for (int i = 0; i < 3; i++) run_instr(tab[i]);
      bus.P_COUNT = 8'h03;
      step();
      step();
      chk("pause_exec_ex", bus.EX_EN, 1);
      bus.RUN = 1'b0;
      step();
      chk("pause_wb", bus.WB_EN, 1);
      bus.P_COUNT = 8'h04;
      ex_base = ex_cnt;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("pause_idle_addr", bus.ROM_ADDR, 3);
         chk("pause_idle_phase", bus.PHASE, 0);
      end
      chk("pause_no_ex", ex_cnt - ex_base, 0);
      bus.RUN = 1'b1;
      step();
      chk("resume_fetch_addr", bus.ROM_ADDR, 3);
      run_instr(tab[4]);

      // Reset during DECODE aborts the instruction
      bus.P_COUNT = 8'h05;
      step();
      chk("abort_dec_addr", bus.ROM_ADDR, 5);
      ex_base = ex_cnt;
      wb_base = wb_cnt;
      reset = 1'b1;
      step();
      chk_reset_vals("abort");
      reset = 1'b0;
      chk("abort_no_ex", ex_cnt - ex_base, 0);
      chk("abort_no_wb", wb_cnt - wb_base, 0);

      // PC at top of ROM, then follow P_COUNT back to 0
      run_instr(v_jmp);
      run_instr(tab[0]);

      chk("no_overlap", overlap_cnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
